// File: rtl/htif_pkg.sv
// Shared types and constants for the host-interface monitor.
// Holds the verdict state encoding, the pass code, the default console
// address and the layout of the registered tohost snoop record.
package htif_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } htif_state_e;

  localparam logic [31:0] HTIF_PASS_CODE    = 32'd1;
  localparam logic [31:0] HTIF_CONSOLE_ADDR = 32'h9a10_0008;

  // Wide enough for the largest supported channel count (8).
  localparam int HTIF_CHAN_W = 3;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            wdata;
    logic [HTIF_CHAN_W-1:0] chan;
  } htif_snoop_t;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int htif_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/htif_console_fifo.sv
// Byte FIFO buffering console output with first-word fall-through reads.
// A push into a full FIFO is only accepted when a pop happens in the same
// cycle; otherwise the byte is dropped and the sticky overflow flag is set.
module htif_console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/htif_monitor.sv
// Passive host-interface monitor: snoops the data bus for tohost writes,
// decodes pass/fail, runs a watchdog and buffers console bytes.
// Define HTIF_MON_CONSOLE_EN to build the console FIFO; without it the
// console outputs are tied low and con_rd_en is ignored.
module htif_monitor
  import htif_pkg::*;
#(
  parameter int          N_TOHOST     = 3,
  parameter logic [31:0] CONSOLE_ADDR = HTIF_CONSOLE_ADDR,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CNT_W        = 32,
  localparam int         HIT_W        = htif_idx_w(N_TOHOST)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [3:0]            bus_be,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  input  logic [32*N_TOHOST-1:0] tohost_addr,
  input  logic [CNT_W-1:0]      timeout_cycles,
  input  logic                  con_rd_en,
  output logic                  con_rd_valid,
  output logic [7:0]            con_rd_data,
  output logic                  con_overflow,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [30:0]           fail_code,
  output logic [HIT_W-1:0]      hit_chan,
  output logic [CNT_W-1:0]      cycle_count
);

  htif_state_e            state;
  htif_snoop_t            snoop;
  logic                   word_write;
  logic                   hit_found;
  logic [HTIF_CHAN_W-1:0] hit_idx;
  logic                   con_push;
  logic                   timeout_hit;

  assign word_write  = bus_req && bus_we && (bus_be == 4'hF);
  assign con_push    = bus_req && bus_we && bus_be[0] && (bus_addr == CONSOLE_ADDR);
  assign timeout_hit = (timeout_cycles != '0) && (cycle_count == timeout_cycles);

  // Channel match; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = N_TOHOST - 1; i >= 0; i--) begin
      if (word_write && (bus_addr == tohost_addr[32*i +: 32])) begin
        hit_found = 1'b1;
        hit_idx   = HTIF_CHAN_W'(i);
      end
    end
  end

  // Snoop stage: capture a tohost hit so the verdict logic sees it next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snoop <= '0;
    end else if (hit_found) begin
      snoop <= '{valid: 1'b1, wdata: bus_wdata, chan: hit_idx};
    end else begin
      snoop.valid <= 1'b0;
    end
  end

  // Verdict state machine with registered status; terminal states freeze everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      fail_code   <= '0;
      hit_chan    <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (snoop.valid && (snoop.wdata != 32'd0)) begin
            done     <= 1'b1;
            hit_chan <= snoop.chan[HIT_W-1:0];
            if (snoop.wdata == HTIF_PASS_CODE) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              fail_code <= snoop.wdata[31:1];
            end
          end else if (timeout_hit) begin
            state     <= ST_TIMEOUT;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

`ifdef HTIF_MON_CONSOLE_EN
  logic con_full;
  logic con_empty;

  htif_console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (con_push),
    .push_data(bus_wdata[7:0]),
    .pop      (con_rd_en),
    .rd_valid (con_rd_valid),
    .rd_data  (con_rd_data),
    .full     (con_full),
    .empty    (con_empty),
    .overflow (con_overflow)
  );

  logic unused_sigs;
  assign unused_sigs = ^{con_full, con_empty, snoop.chan};
`else
  assign con_rd_valid = 1'b0;
  assign con_rd_data  = 8'h00;
  assign con_overflow = 1'b0;

  logic [31:0] unused_depth;
  logic        unused_sigs;
  assign unused_depth = 32'(FIFO_DEPTH);
  assign unused_sigs  = ^{con_push, con_rd_en, unused_depth, snoop.chan};
`endif

endmodule
